// File: rtl/aes_round_ctrl.sv
// AES-128 encryption round sequencer: start pulse -> initial load -> NR round strobes
// with round index and Rcon -> result held until the downstream accepts it.
module aes_round_ctrl #(
    parameter int NR = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       out_ready,
    output logic       busy,
    output logic       load_en,
    output logic       round_en,
    output logic       final_rnd,
    output logic [3:0] round_idx,
    output logic [7:0] rcon,
    output logic       out_valid,
    output logic       done,
    output logic       start_drop
);

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ROUND = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t     state_reg, state_next;
    logic [3:0] idx_reg, idx_next;
    logic [7:0] rcon_reg, rcon_next;
    logic       first_hold_reg, first_hold_next;
    logic       drop_reg, drop_next;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            idx_reg        <= 4'd0;
            rcon_reg       <= 8'h00;
            first_hold_reg <= 1'b0;
            drop_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            rcon_reg       <= rcon_next;
            first_hold_reg <= first_hold_next;
            drop_reg       <= drop_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        idx_next        = idx_reg;
        rcon_next       = rcon_reg;
        first_hold_next = 1'b0;
        drop_next       = drop_reg;
        case (state_reg)
            IDLE: begin
                if (!abort && start) begin
                    state_next = LOAD;
                    drop_next  = 1'b0;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_next = IDLE;
                end else begin
                    state_next = ROUND;
                    idx_next   = 4'd1;
                    rcon_next  = 8'h01;
                    if (start) drop_next = 1'b1;
                end
            end
            ROUND: begin
                if (abort) begin
                    state_next = IDLE;
                    idx_next   = 4'd0;
                    rcon_next  = 8'h00;
                end else begin
                    if (start) drop_next = 1'b1;
                    if (idx_reg == LAST_ROUND) begin
                        state_next      = HOLD;
                        idx_next        = 4'd0;
                        rcon_next       = 8'h00;
                        first_hold_next = 1'b1;
                    end else begin
                        idx_next  = idx_reg + 4'd1;
                        rcon_next = xtime(rcon_reg);
                    end
                end
            end
            HOLD: begin
                // A start coinciding with acceptance is a back-to-back run, not a drop.
                if (abort) begin
                    state_next = IDLE;
                end else if (out_ready) begin
                    if (start) begin
                        state_next = LOAD;
                        drop_next  = 1'b0;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (start) begin
                    drop_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = 4'd0;
                rcon_next  = 8'h00;
            end
        endcase
    end

    assign busy       = (state_reg != IDLE);
    assign load_en    = (state_reg == LOAD);
    assign round_en   = (state_reg == ROUND);
    assign final_rnd  = (state_reg == ROUND) && (idx_reg == LAST_ROUND);
    assign round_idx  = idx_reg;
    assign rcon       = rcon_reg;
    assign out_valid  = (state_reg == HOLD);
    assign done       = first_hold_reg;
    assign start_drop = drop_reg;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: per-cycle vector table through a scoreboard
// queue, plus a hand-written asynchronous-reset sequence.
module tb_aes_round_ctrl;

    localparam int NR = 10;

    logic       clk, rst, start, abort, out_ready;
    logic       busy, load_en, round_en, final_rnd, out_valid, done, start_drop;
    logic [3:0] round_idx;
    logic [7:0] rcon;

    aes_round_ctrl #(.NR(NR)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .out_ready(out_ready),
        .busy(busy), .load_en(load_en), .round_en(round_en), .final_rnd(final_rnd),
        .round_idx(round_idx), .rcon(rcon), .out_valid(out_valid), .done(done),
        .start_drop(start_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {busy, load_en, round_en, final_rnd, round_idx, rcon, out_valid, done, start_drop}
    typedef struct packed {
        logic        start;
        logic        abort;
        logic        out_ready;
        logic [18:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [18:0] sb[$];
    logic [7:0]  rcon_tab[10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
    int          n_vec = 0;
    int          n_err = 0;

    function automatic logic [18:0] outs_now();
        return {busy, load_en, round_en, final_rnd, round_idx, rcon, out_valid, done, start_drop};
    endfunction

    function automatic void push(logic s, logic a, logic r, logic bz, logic ld, logic rd,
                                 logic fn, logic [3:0] ix, logic [7:0] rc, logic ov,
                                 logic dn, logic dp);
        vec_t v;
        v.start = s; v.abort = a; v.out_ready = r;
        v.exp = {bz, ld, rd, fn, ix, rc, ov, dn, dp};
        vecs.push_back(v);
    endfunction

    function automatic void v_idle(logic s, logic a, logic dp);
        push(s, a, 1'b0, 0, 0, 0, 0, 4'd0, 8'h00, 0, 0, dp);
    endfunction
    function automatic void v_load(logic s, logic dp);
        push(s, 1'b0, 1'b0, 1, 1, 0, 0, 4'd0, 8'h00, 0, 0, dp);
    endfunction
    function automatic void v_round(int i, logic s, logic a, logic dp);
        push(s, a, 1'b0, 1, 0, 1, (i == NR), 4'(i), rcon_tab[i-1], 0, 0, dp);
    endfunction
    function automatic void v_hold(logic first, logic s, logic a, logic r, logic dp);
        push(s, a, r, 1, 0, 0, 0, 4'd0, 8'h00, 1, first, dp);
    endfunction

    task automatic check(string name, logic [18:0] act, logic [18:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got bz/ld/rd/fn=%b idx=%0d rcon=%h ov/dn/dp=%b, want bz/ld/rd/fn=%b idx=%0d rcon=%h ov/dn/dp=%b",
                     name, act[18:15], act[14:11], act[10:3], act[2:0],
                     req[18:15], req[14:11], req[10:3], req[2:0]);
        end
    endtask

    task automatic build_table();
        // reset state
        v_idle(0, 0, 0); v_idle(0, 0, 0);
        // nominal
        v_idle(1, 0, 0); v_load(0, 0);
        for (int i = 1; i <= NR; i++) v_round(i, 0, 0, 0);
        v_hold(1, 0, 0, 1, 0); v_idle(0, 0, 0);
        // back-to-back
        v_idle(1, 0, 0); v_load(0, 0);
        for (int i = 1; i <= NR; i++) v_round(i, 0, 0, 0);
        v_hold(1, 1, 0, 1, 0); v_load(0, 0);
        for (int i = 1; i <= NR; i++) v_round(i, 0, 0, 0);
        v_hold(1, 0, 0, 1, 0); v_idle(0, 0, 0);
        // start during run (issued in round 5), then next start clears the flag
        v_idle(1, 0, 0); v_load(0, 0);
        for (int i = 1; i <= NR; i++) v_round(i, (i == 5), 0, (i >= 6));
        v_hold(1, 0, 0, 1, 1); v_idle(0, 0, 1);
        v_idle(1, 0, 1); v_load(0, 0);
        // backpressure with a dropped start while held
        for (int i = 1; i <= NR; i++) v_round(i, 0, 0, 0);
        v_hold(1, 0, 0, 0, 0); v_hold(0, 0, 0, 0, 0); v_hold(0, 1, 0, 0, 0);
        v_hold(0, 0, 0, 0, 1); v_hold(0, 0, 0, 0, 1); v_hold(0, 0, 0, 1, 1);
        v_idle(0, 0, 1);
        // abort at round 3; abort keeps start_drop; abort+start in IDLE loads nothing
        v_idle(1, 0, 1); v_load(0, 0);
        v_round(1, 0, 0, 0); v_round(2, 1, 0, 0); v_round(3, 0, 1, 1);
        v_idle(0, 0, 1); v_idle(1, 1, 1); v_idle(0, 0, 1); v_idle(0, 0, 1);
        // abort together with out_ready in HOLD discards the result
        v_idle(1, 0, 1); v_load(0, 0);
        for (int i = 1; i <= NR; i++) v_round(i, 0, 0, 0);
        v_hold(1, 0, 1, 1, 0); v_idle(0, 0, 0); v_idle(0, 0, 0);
    endtask

    initial begin
        bit found;
        rst = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        build_table();
        #1 check("reset_async", outs_now(), 19'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;

        for (int k = 0; k < vecs.size(); k++) begin
            @(posedge clk);
            #1;
            start = vecs[k].start; abort = vecs[k].abort; out_ready = vecs[k].out_ready;
            sb.push_back(vecs[k].exp);
            @(negedge clk);
            check($sformatf("vec%0d", k), outs_now(), sb.pop_front());
        end

        // reset asserted mid-run at round 5, no clock edge before checking
        @(posedge clk); #1 start = 1'b1; abort = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(posedge clk); #1;
            if (round_idx == 4'd5) found = 1;
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL reach_round5: round_idx=%0d, want 5 within 20 cycles", round_idx);
        end
        #1 rst = 1'b0;
        #1 check("reset_midrun", outs_now(), 19'd0);
        @(negedge clk); #2 rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("post_reset%0d", c), outs_now(), 19'd0);
        end
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check("restart_load", outs_now(), {1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
